ssd_scan_display: RTL and testbench

//  Multi-digit seven-segment display driver for the clock/timer datapath. Captures an unsigned binary

---
 rtl/ssd_pkg.sv | 34 +++
 rtl/ssd_scan_display_if.sv | 24 ++
 rtl/ssd_scan_display_bin2bcd.sv | 77 +++++++
 rtl/ssd_scan_display.sv | 93 +++++++++
 tb/tb_ssd_scan_display.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan display.
// Segment order is {A,B,C,D,E,F,G}, active-high.
package ssd_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_t;

    function automatic logic [63:0] pow10(input int e);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < e; i++) r = r * 64'd10;
        return r;
    endfunction

    // Codes 10..15 never come out of the converter; they show blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        s = SEG_BLANK;
        for (int i = 0; i < 10; i++)
            if (nib == 4'(i)) s = SEG_DIGIT[i];
        return s;
    endfunction

endpackage

// File: rtl/ssd_scan_display_if.sv
// Load/status/display bundle between the timer datapath and the
// display driver; the driver side is the slave.
interface ssd_scan_display_if #(
    parameter int BIN_W      = 6,
    parameter int NUM_DIGITS = 2
);
    logic [BIN_W-1:0]      value;
    logic                  load;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] an;

    modport master (
        output value, load,
        input  busy, done, ovf, seg, an
    );

    modport slave (
        input  value, load,
        output busy, done, ovf, seg, an
    );
endinterface

// File: rtl/ssd_scan_display_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter.
// Digits above NUM_DIGITS are dropped; ovf flags that case.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int BIN_W      = 6,
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf
);
    localparam int         SW   = 4 * NUM_DIGITS + BIN_W;
    localparam int         CW   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [63:0] MAXV = pow10(NUM_DIGITS) - 64'd1;

    conv_state_t   r_state;
    logic [SW-1:0] r_sh;
    logic [CW-1:0] r_cnt;
    logic          r_ovf_nx;
    logic [SW-1:0] w_adj;

    // add 3 to every BCD nibble that is 5 or more before the shift
    always_comb begin
        w_adj = r_sh;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (r_sh[BIN_W+4*i +: 4] >= 4'd5)
                w_adj[BIN_W+4*i +: 4] = r_sh[BIN_W+4*i +: 4] + 4'd3;
    end

    // IDLE -> SHIFT (BIN_W cycles) -> COMMIT -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sh     <= '0;
            r_cnt    <= '0;
            r_ovf_nx <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sh     <= {{(4*NUM_DIGITS){1'b0}}, bin};
                        r_ovf_nx <= (64'(bin) > MAXV);
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_sh  <= w_adj << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(BIN_W - 1)) begin
                        done    <= 1'b1;
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    bcd     <= r_sh[SW-1 -: 4*NUM_DIGITS];
                    ovf     <= r_ovf_nx;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ssd_scan_display.sv
// Multiplexed seven-segment driver: converter plus free-running
// digit scanner with blanking, dash-on-overflow and polarity.
module ssd_scan_display
    import ssd_pkg::*;
#(
    parameter int BIN_W       = 6,
    parameter int NUM_DIGITS  = 2,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1,
    parameter int ACTIVE_LOW  = 0
) (
    input logic              clk,
    input logic              rst,
    ssd_scan_display_if.slave bus
);
    localparam int ND = NUM_DIGITS;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;

    logic [4*ND-1:0] w_bcd;
    logic            w_ovf;
    logic            w_busy;
    logic            w_done;
    logic [RW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic [3:0]      w_nib;
    logic            w_lz;
    logic [6:0]      w_seg;
    logic [ND-1:0]   w_an;
    logic [6:0]      r_seg;
    logic [ND-1:0]   r_an;

    bin2bcd_seq #(
        .BIN_W     (BIN_W),
        .NUM_DIGITS(ND)
    ) u_conv (
        .clk  (clk),
        .rst  (rst),
        .start(bus.load),
        .bin  (bus.value),
        .busy (w_busy),
        .done (w_done),
        .bcd  (w_bcd),
        .ovf  (w_ovf)
    );

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.ovf  = w_ovf;

    // refresh counter; the digit index steps on its terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == RW'(REFRESH_DIV - 1)) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IW'(ND - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // pick the scanned digit and decide dash / blank / numeral
    always_comb begin
        w_nib = w_bcd[{r_idx, 2'b00} +: 4];
        w_lz  = 1'b1;
        for (int i = 0; i < ND; i++)
            if (i >= int'(r_idx) && w_bcd[4*i +: 4] != 4'd0)
                w_lz = 1'b0;
        if (w_ovf)
            w_seg = SEG_DASH;
        else if (BLANK_LZ != 0 && r_idx != '0 && w_lz)
            w_seg = SEG_BLANK;
        else
            w_seg = bcd_to_seg(w_nib);
        w_an = ND'(1) << r_idx;
    end

    // output registers, kept active-high internally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= SEG_DIGIT[0];
            r_an  <= ND'(1);
        end else begin
            r_seg <= w_seg;
            r_an  <= w_an;
        end
    end

    assign bus.seg = (ACTIVE_LOW != 0) ? ~r_seg : r_seg;
    assign bus.an  = (ACTIVE_LOW != 0) ? ~r_an  : r_an;
endmodule

// File: tb/tb_ssd_scan_display.sv
// Bench for ssd_scan_display: two configurations checked every
// cycle against a decimal-arithmetic model, plus literal spot checks.
module tb_ssd_scan_display;
    localparam int RD = 4;
    localparam int PBW  [2] = '{7, 11};
    localparam int PND  [2] = '{2, 3};
    localparam int PBLZ [2] = '{1, 0};
    localparam int PAL  [2] = '{0, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld [2] = '{1'b0, 1'b0};
    logic [10:0] vl [2] = '{11'd0, 11'd0};

    ssd_scan_display_if #(.BIN_W(7),  .NUM_DIGITS(2)) ifa ();
    ssd_scan_display_if #(.BIN_W(11), .NUM_DIGITS(3)) ifb ();

    assign ifa.load  = ld[0];
    assign ifa.value = vl[0][6:0];
    assign ifb.load  = ld[1];
    assign ifb.value = vl[1];

    ssd_scan_display #(
        .BIN_W(7), .NUM_DIGITS(2), .REFRESH_DIV(RD),
        .BLANK_LZ(1), .ACTIVE_LOW(0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    ssd_scan_display #(
        .BIN_W(11), .NUM_DIGITS(3), .REFRESH_DIV(RD),
        .BLANK_LZ(0), .ACTIVE_LOW(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    logic [6:0] aseg  [2];
    logic [7:0] aan   [2];
    logic       abusy [2];
    logic       adone [2];
    logic       aovf  [2];

    assign aseg[0]  = ifa.seg;
    assign aan[0]   = {6'd0, ifa.an};
    assign abusy[0] = ifa.busy;
    assign adone[0] = ifa.done;
    assign aovf[0]  = ifa.ovf;
    assign aseg[1]  = ifb.seg;
    assign aan[1]   = {5'd0, ifb.an};
    assign abusy[1] = ifb.busy;
    assign adone[1] = ifb.done;
    assign aovf[1]  = ifb.ovf;

    int checks = 0;
    int errors = 0;
    int dcnt [2] = '{0, 0};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int p10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] dseg(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // what digit i of committed value v must look like (active-high)
    function automatic logic [6:0] exp_digit(input int v, input bit ov,
                                             input int i, input int nd,
                                             input int blz);
        int t;
        if (ov) return 7'b0000001;
        t = v % p10(nd);
        if (blz != 0 && i > 0 && t / p10(i) == 0) return 7'b0000000;
        return dseg((t / p10(i)) % 10);
    endfunction

    function automatic logic [6:0] pol_seg(input int k, input logic [6:0] s);
        return (PAL[k] != 0) ? ~s : s;
    endfunction

    function automatic logic [7:0] pol_an(input int k, input int idx);
        logic [7:0] oh;
        logic [7:0] m;
        oh = 8'(1 << idx);
        m  = 8'((1 << PND[k]) - 1);
        return (PAL[k] != 0) ? (~oh & m) : oh;
    endfunction

    function automatic logic [6:0] act_seg(input int k);
        return (PAL[k] != 0) ? ~aseg[k] : aseg[k];
    endfunction

    function automatic logic [7:0] act_an(input int k);
        logic [7:0] m;
        m = 8'((1 << PND[k]) - 1);
        return (PAL[k] != 0) ? (~aan[k] & m) : aan[k];
    endfunction

    // behavioural model: counts edges since reset, tracks a pending
    // conversion as a countdown and the committed decimal value
    int         m_n    [2];
    int         m_left [2];
    int         m_pend [2];
    int         m_val  [2];
    bit         m_ovf  [2];
    logic [6:0] e_seg  [2];
    logic [7:0] e_an   [2];
    bit         e_busy [2];
    bit         e_done [2];
    bit         mvalid = 1'b0;

    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_n[k]    = 0;
                m_left[k] = 0;
                m_val[k]  = 0;
                m_ovf[k]  = 1'b0;
                e_seg[k]  = pol_seg(k, dseg(0));
                e_an[k]   = pol_an(k, 0);
            end else begin
                int idx;
                m_n[k]++;
                idx      = ((m_n[k] - 1) / RD) % PND[k];
                e_seg[k] = pol_seg(k, exp_digit(m_val[k], m_ovf[k], idx,
                                                PND[k], PBLZ[k]));
                e_an[k]  = pol_an(k, idx);
                if (m_left[k] == 0) begin
                    if (ld[k]) begin
                        m_left[k] = PBW[k] + 1;
                        m_pend[k] = int'(vl[k]) & ((1 << PBW[k]) - 1);
                    end
                end else begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_val[k] = m_pend[k];
                        m_ovf[k] = (m_pend[k] > p10(PND[k]) - 1);
                    end
                end
            end
            e_busy[k] = (m_left[k] > 0);
            e_done[k] = (m_left[k] == 1);
        end
        if (rst) mvalid = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (mvalid) begin
                chk($sformatf("seg%0d", k),  int'(aseg[k]),  int'(e_seg[k]));
                chk($sformatf("an%0d", k),   int'(aan[k]),   int'(e_an[k]));
                chk($sformatf("busy%0d", k), int'(abusy[k]), int'(e_busy[k]));
                chk($sformatf("done%0d", k), int'(adone[k]), int'(e_done[k]));
                chk($sformatf("ovf%0d", k),  int'(aovf[k]),  int'(m_ovf[k]));
            end
            if (adone[k] === 1'b1) dcnt[k]++;
        end
    end

    task automatic ld_go(input int k, input int v);
        @(posedge clk);
        #1;
        vl[k] = 11'(v);
        ld[k] = 1'b1;
        @(posedge clk);
        #1;
        ld[k] = 1'b0;
    endtask

    task automatic conv(input int k, input int v, output int bc);
        int c = 0;
        bc = 0;
        ld_go(k, v);
        do begin
            @(negedge clk);
            c++;
            if (abusy[k] === 1'b1) bc++;
        end while (adone[k] !== 1'b1 && c < 60);
        chk($sformatf("done_seen%0d_v%0d", k, v), int'(adone[k] === 1'b1), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic show(input int k, input int d, output logic [6:0] s);
        int c = 0;
        while (act_an(k) != 8'(1 << d) && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk($sformatf("scan%0d_d%0d", k, d), int'(act_an(k)), 1 << d);
        s = act_seg(k);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [6:0] s;
    int         bc;
    int         base;
    logic [7:0] cur;
    int         hold;
    int         c;
    logic [7:0] exp_an [3] = '{8'h05, 8'h03, 8'h06};

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_seg_a",  int'(aseg[0]), 7'b1111110);
        chk("rst_an_a",   int'(aan[0]), 8'h01);
        chk("rst_busy_a", int'(abusy[0]), 0);
        chk("rst_done_a", int'(adone[0]), 0);
        chk("rst_ovf_a",  int'(aovf[0]), 0);
        chk("rst_an_b",   int'(aan[1]), 8'h06);
        chk("rst_seg_b",  int'(aseg[1]), 7'b0000001);

        cur = aan[1];
        c = 0;
        while (aan[1] == cur && c < 20) begin
            @(negedge clk);
            c++;
        end
        for (int j = 0; j < 3; j++) begin
            cur  = aan[1];
            hold = 0;
            chk($sformatf("scan_b_an%0d", j), int'(cur), int'(exp_an[j]));
            chk($sformatf("scan_b_seg%0d", j), int'(aseg[1]), 7'b0000001);
            while (aan[1] == cur && hold < 20) begin
                @(negedge clk);
                hold++;
            end
            chk($sformatf("scan_b_hold%0d", j), hold, RD);
        end
        show(0, 1, s);
        chk("rst_blank_a1", int'(s), 7'b0000000);

        conv(0, 42, bc);
        chk("a42_busy", bc, 8);
        show(0, 0, s);
        chk("a42_d0", int'(s), 7'b1101101);
        show(0, 1, s);
        chk("a42_d1", int'(s), 7'b0110011);

        conv(0, 7, bc);
        show(0, 1, s);
        chk("a7_d1_blank", int'(s), 7'b0000000);
        show(0, 0, s);
        chk("a7_d0", int'(s), 7'b1110000);

        conv(1, 7, bc);
        chk("b7_busy", bc, 12);
        show(1, 2, s);
        chk("b7_d2_noblank", int'(s), 7'b1111110);
        show(1, 1, s);
        chk("b7_d1_noblank", int'(s), 7'b1111110);

        conv(0, 100, bc);
        chk("a100_ovf", int'(aovf[0]), 1);
        show(0, 0, s);
        chk("a100_d0", int'(s), 7'b0000001);
        show(0, 1, s);
        chk("a100_d1", int'(s), 7'b0000001);

        conv(0, 99, bc);
        chk("a99_ovf", int'(aovf[0]), 0);
        show(0, 0, s);
        chk("a99_d0", int'(s), 7'b1111011);
        show(0, 1, s);
        chk("a99_d1", int'(s), 7'b1111011);

        conv(1, 1234, bc);
        chk("b1234_ovf", int'(aovf[1]), 1);
        show(1, 2, s);
        chk("b1234_d2", int'(s), 7'b0000001);

        base = dcnt[0];
        ld_go(0, 63);
        repeat (2) @(posedge clk);
        ld_go(0, 12);
        repeat (20) @(negedge clk);
        chk("a63_one_done", dcnt[0] - base, 1);
        show(0, 0, s);
        chk("a63_d0", int'(s), 7'b1111001);
        show(0, 1, s);
        chk("a63_d1", int'(s), 7'b1011111);

        base = dcnt[0];
        ld_go(0, 88);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", dcnt[0] - base, 0);
        show(0, 0, s);
        chk("abort_d0", int'(s), 7'b1111110);
        show(0, 1, s);
        chk("abort_d1", int'(s), 7'b0000000);

        for (int it = 0; it < 1500; it++) begin
            @(posedge clk);
            #1;
            rst = (it % 500 == 250);
            for (int k = 0; k < 2; k++) begin
                ld[k] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 3) == 0)
                    vl[k] = 11'($urandom_range(0, 9));
                else
                    vl[k] = 11'($urandom) & ((k == 0) ? 11'h07f : 11'h7ff);
            end
        end
        #1;
        rst   = 1'b0;
        ld[0] = 1'b0;
        ld[1] = 1'b0;
        repeat (30) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
